// File: rtl/regfile_pkg.sv
// Shared register-file constants for the writeback arbiter.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % N);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = idx;
      end
    end
  end

  // With no grant the pointer holds so priority is not lost on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port plus a per-register busy scoreboard.
// Optional decode bypass outputs are enabled with the REGFILE_WB_BYPASS_EN macro.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int XLEN  = regfile_pkg::XLEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [5*N_REQ-1:0]      req_rd_i,
  input  logic [XLEN*N_REQ-1:0]   req_data_i,
  output logic                    rf_we_o,
  output logic [REG_ADDR_W-1:0]   rf_rd_o,
  output logic [XLEN-1:0]         rf_data_o,
  input  logic                    rsv_valid_i,
  input  logic [REG_ADDR_W-1:0]   rsv_rd_i,
  input  logic [REG_ADDR_W-1:0]   q_rs1_i,
  input  logic [REG_ADDR_W-1:0]   q_rs2_i,
  output logic                    q_busy1_o,
  output logic                    q_busy2_o,
  output logic                    waw_err_o
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                    byp1_hit_o,
  output logic                    byp2_hit_o,
  output logic [XLEN-1:0]         byp_data_o
`endif
);
  // Handshake: a requester raises valid and holds rd/data stable; the transfer
  // happens in the cycle valid&ready is high. ready never depends on rf state.
  logic [N_REQ-1:0]      grant;
  logic                  grant_any;
  logic [REG_ADDR_W-1:0] g_rd;
  logic [XLEN-1:0]       g_data;
  logic                  wr_en;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .valid (req_valid_i),
    .grant (grant)
  );

  assign req_ready_o = grant;
  assign grant_any   = |grant;

  always_comb begin
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        g_rd   = req_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
        g_data = req_data_i[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are consumed but never reach the register file.
  assign wr_en = grant_any && (g_rd != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o   <= 1'b0;
      rf_rd_o   <= '0;
      rf_data_o <= '0;
    end else begin
      rf_we_o <= wr_en;
      if (wr_en) begin
        rf_rd_o   <= g_rd;
        rf_data_o <= g_data;
      end
    end
  end

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                rsv_en;
  logic                waw_hit;

  // Reserve is applied after clear so a same-cycle reserve+clear leaves the register busy.
  always_comb begin
    busy_next = busy;
    rsv_en    = rsv_valid_i && (rsv_rd_i != '0);
    waw_hit   = rsv_en && busy[rsv_rd_i] && !(wr_en && (g_rd == rsv_rd_i));
    if (wr_en) busy_next[g_rd] = 1'b0;
    if (rsv_en) busy_next[rsv_rd_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy      <= '0;
      waw_err_o <= 1'b0;
    end else begin
      busy      <= busy_next;
      waw_err_o <= waw_err_o | waw_hit;
    end
  end

  assign q_busy1_o = busy[q_rs1_i];
  assign q_busy2_o = busy[q_rs2_i];

`ifdef REGFILE_WB_BYPASS_EN
  assign byp1_hit_o = rf_we_o & (rf_rd_o == q_rs1_i) & (q_rs1_i != '0);
  assign byp2_hit_o = rf_we_o & (rf_rd_o == q_rs2_i) & (q_rs2_i != '0);
  assign byp_data_o = rf_data_o;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model with an expected-write queue.
module tb_regfile_wb_arbiter;
  localparam int N    = 2;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4:0]      rd_in [N];
  logic [XLEN-1:0] data_in [N];
  logic [5*N-1:0]  req_rd;
  logic [XLEN*N-1:0] req_data;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic            rsv_valid;
  logic [4:0]      rsv_rd;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic            q_busy1;
  logic            q_busy2;
  logic            waw_err;
`ifdef REGFILE_WB_BYPASS_EN
  logic            byp1_hit;
  logic            byp2_hit;
  logic [XLEN-1:0] byp_data;
`endif

  assign req_rd   = {rd_in[1], rd_in[0]};
  assign req_data = {data_in[1], data_in[0]};

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XLEN)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_rd_i    (req_rd),
    .req_data_i  (req_data),
    .rf_we_o     (rf_we),
    .rf_rd_o     (rf_rd),
    .rf_data_o   (rf_data),
    .rsv_valid_i (rsv_valid),
    .rsv_rd_i    (rsv_rd),
    .q_rs1_i     (q_rs1),
    .q_rs2_i     (q_rs2),
    .q_busy1_o   (q_busy1),
    .q_busy2_o   (q_busy2),
    .waw_err_o   (waw_err)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .byp1_hit_o  (byp1_hit),
    .byp2_hit_o  (byp2_hit),
    .byp_data_o  (byp_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              m_ptr;
  bit [31:0]       m_busy;
  bit              m_waw;
  bit              m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic [5+XLEN-1:0] exp_q[$];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    rsv_valid = 1'b0;
    rsv_rd    = '0;
    q_rs1     = '0;
    q_rs2     = '0;
    for (int r = 0; r < N; r++) begin
      rd_in[r]   = '0;
      data_in[r] = '0;
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int p);
    logic [N-1:0] g;
    int idx;
    g = '0;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (v[idx] && g == '0) g[idx] = 1'b1;
    end
    return g;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rd_in[0]  = 5'd5;
    data_in[0] = 32'h1111_1111;
    rsv_valid = 1'b1;
    rsv_rd    = 5'd3;
    q_rs1     = 5'd3;
    q_rs2     = 5'd5;
    repeat (3) tick();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
    checks++;
    if (rf_rd !== 5'd0 || rf_data !== 32'd0) begin
      errors++; $display("FAIL reset_rd_data: got %0d/%h want 0/0", rf_rd, rf_data);
    end
    checks++;
    if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b%b want 00", q_busy1, q_busy2);
    end
    checks++;
    if (waw_err !== 1'b0) begin errors++; $display("FAIL reset_waw: got %b want 0", waw_err); end
    idle();
    rst_n = 1'b1;
    tick();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_release_we: got %b want 0", rf_we); end
  endtask

  task automatic test_contention();
    rd_in[0] = 5'd5; data_in[0] = 32'hAAAA_0005;
    rd_in[1] = 5'd6; data_in[1] = 32'hBBBB_0006;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_grant0: got %b want 01", req_ready); end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hAAAA_0005) begin
      errors++; $display("FAIL cont_write_x5: got we=%b rd=%0d data=%h want 1/5/aaaa0005", rf_we, rf_rd, rf_data);
    end
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL cont_grant1: got %b want 10", req_ready); end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd6 || rf_data !== 32'hBBBB_0006) begin
      errors++; $display("FAIL cont_write_x6: got we=%b rd=%0d data=%h want 1/6/bbbb0006", rf_we, rf_rd, rf_data);
    end
    req_valid = 2'b00;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL cont_idle_ready: got %b want 00", req_ready); end
    tick();
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd6 || rf_data !== 32'hBBBB_0006) begin
      errors++; $display("FAIL cont_hold: got we=%b rd=%0d data=%h want 0/6/bbbb0006", rf_we, rf_rd, rf_data);
    end
    checks++;
    if (waw_err !== 1'b0) begin errors++; $display("FAIL cont_clear_nonbusy_waw: got %b want 0", waw_err); end
  endtask

  task automatic test_x0_write();
    rd_in[1] = 5'd0; data_in[1] = 32'hDEAD_BEEF;
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd6 || rf_data !== 32'hBBBB_0006) begin
      errors++; $display("FAIL x0_no_write: got we=%b rd=%0d data=%h want 0/6/bbbb0006", rf_we, rf_rd, rf_data);
    end
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL x0_ready_drop: got %b want 00", req_ready); end
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    q_rs1 = 5'd7; q_rs2 = 5'd7;
    #1;
    checks++;
    if (q_busy1 !== 1'b0) begin errors++; $display("FAIL sb_pre_reserve: got %b want 0", q_busy1); end
    tick();
    rsv_valid = 1'b0;
    #1;
    checks++;
    if (q_busy1 !== 1'b1 || q_busy2 !== 1'b1) begin
      errors++; $display("FAIL sb_reserved: got %b%b want 11", q_busy1, q_busy2);
    end
    rd_in[0] = 5'd7; data_in[0] = 32'h0000_0077;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01 || q_busy1 !== 1'b1) begin
      errors++; $display("FAIL sb_grant_cycle: got ready=%b busy=%b want 01/1", req_ready, q_busy1);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (q_busy1 !== 1'b0 || rf_we !== 1'b1 || rf_rd !== 5'd7) begin
      errors++; $display("FAIL sb_cleared: got busy=%b we=%b rd=%0d want 0/1/7", q_busy1, rf_we, rf_rd);
    end
    rsv_valid = 1'b1;
    tick();
    rsv_valid = 1'b0;
    req_valid = 2'b01;
    rsv_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL sb_same_cycle_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    rsv_valid = 1'b0;
    checks++;
    if (q_busy1 !== 1'b1 || waw_err !== 1'b0) begin
      errors++; $display("FAIL sb_reserve_wins: got busy=%b waw=%b want 1/0", q_busy1, waw_err);
    end
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    checks++;
    if (q_busy1 !== 1'b0) begin errors++; $display("FAIL sb_final_clear: got %b want 0", q_busy1); end
  endtask

  task automatic test_waw();
    rsv_valid = 1'b1; rsv_rd = 5'd0; q_rs1 = 5'd0;
    tick();
    tick();
    rsv_valid = 1'b0;
    checks++;
    if (waw_err !== 1'b0 || q_busy1 !== 1'b0) begin
      errors++; $display("FAIL waw_x0_ignored: got waw=%b busy=%b want 0/0", waw_err, q_busy1);
    end
    rsv_valid = 1'b1; rsv_rd = 5'd9; q_rs1 = 5'd9;
    tick();
    checks++;
    if (q_busy1 !== 1'b1 || waw_err !== 1'b0) begin
      errors++; $display("FAIL waw_first: got busy=%b waw=%b want 1/0", q_busy1, waw_err);
    end
    tick();
    rsv_valid = 1'b0;
    checks++;
    if (waw_err !== 1'b1 || q_busy1 !== 1'b1) begin
      errors++; $display("FAIL waw_second: got waw=%b busy=%b want 1/1", waw_err, q_busy1);
    end
    rd_in[0] = 5'd9; data_in[0] = 32'h0000_0099;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (waw_err !== 1'b1 || q_busy1 !== 1'b0) begin
      errors++; $display("FAIL waw_sticky: got waw=%b busy=%b want 1/0", waw_err, q_busy1);
    end
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (waw_err !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL waw_reset_clears: got waw=%b we=%b want 0/0", waw_err, rf_we);
    end
  endtask

  task automatic test_reset_mid_transfer();
    rd_in[0] = 5'd4; data_in[0] = 32'h0000_0044;
    req_valid = 2'b01;
    tick();
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b want 01", req_ready); end
    #1;
    rst_n = 1'b0;
    tick();
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0) begin
      errors++; $display("FAIL mid_discard: got we=%b rd=%0d data=%h want 0/0/0", rf_we, rf_rd, rf_data);
    end
    req_valid = 2'b11;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_ptr_reset: got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    rd_in[0] = 5'd3; data_in[0] = 32'h1234_5678;
    req_valid = 2'b01;
    q_rs2 = 5'd3;
    tick();
    req_valid = 2'b00;
    checks++;
    if (byp2_hit !== 1'b1 || byp_data !== 32'h1234_5678) begin
      errors++; $display("FAIL byp_hit: got hit=%b data=%h want 1/12345678", byp2_hit, byp_data);
    end
    q_rs2 = 5'd0;
    #1;
    checks++;
    if (byp2_hit !== 1'b0) begin errors++; $display("FAIL byp_x0: got %b want 0", byp2_hit); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] g;
    bit [N-1:0] pend;
    int gi;
    logic [4:0] rdg;
    logic [5+XLEN-1:0] e;
    bit clr;
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m_ptr = 0; m_busy = '0; m_waw = 1'b0; m_we = 1'b0;
    m_rd = '0; m_data = '0; exp_q.delete(); pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r]    = 1'b1;
          rd_in[r]   = 5'($urandom_range(0, 31));
          data_in[r] = $urandom;
        end
      end
      req_valid = pend;
      rsv_valid = ($urandom_range(0, 5) == 0);
      rsv_rd    = 5'($urandom_range(0, 31));
      q_rs1     = 5'($urandom_range(0, 31));
      q_rs2     = 5'($urandom_range(0, 31));
      #1;
      g = model_grant(pend, m_ptr);
      checks++;
      if (req_ready !== g) begin errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, g); end
      checks++;
      if (q_busy1 !== m_busy[q_rs1] || q_busy2 !== m_busy[q_rs2]) begin
        errors++;
        $display("FAIL rnd_busy c=%0d: got %b%b want %b%b", c, q_busy1, q_busy2, m_busy[q_rs1], m_busy[q_rs2]);
      end
      checks++;
      if (waw_err !== m_waw) begin errors++; $display("FAIL rnd_waw c=%0d: got %b want %b", c, waw_err, m_waw); end
      @(posedge clk);
      clr = 1'b0; m_we = 1'b0; rdg = '0;
      if (g != '0) begin
        gi = g[1] ? 1 : 0;
        m_ptr = (gi + 1) % N;
        pend[gi] = 1'b0;
        rdg = rd_in[gi];
        if (rdg != 5'd0) begin
          exp_q.push_back({rdg, data_in[gi]});
          m_busy[rdg] = 1'b0;
          clr = 1'b1;
          m_we = 1'b1;
        end
      end
      if (rsv_valid && rsv_rd != 5'd0) begin
        if (m_busy[rsv_rd] && !(clr && rdg == rsv_rd)) m_waw = 1'b1;
        m_busy[rsv_rd] = 1'b1;
      end
      #1;
      checks++;
      if (rf_we !== m_we) begin errors++; $display("FAIL rnd_we c=%0d: got %b want %b", c, rf_we, m_we); end
      if (m_we && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_rd = e[5+XLEN-1:XLEN];
        m_data = e[XLEN-1:0];
      end
      checks++;
      if (rf_rd !== m_rd || rf_data !== m_data) begin
        errors++; $display("FAIL rnd_wdata c=%0d: got %0d/%h want %0d/%h", c, rf_rd, rf_data, m_rd, m_data);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_contention();
    test_x0_write();
    test_scoreboard();
    test_waw();
    test_reset_mid_transfer();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
